// File: rtl/exc_req_ctrl.sv
// ----------------------------------------------------------------------------
// exc_req_ctrl
// Exception-request controller that sits between the single-cycle datapath
// control and CP0. It takes trap requests from execute (SYSCALL, BREAK, TEQ)
// and one external interrupt line, and filters them against the CP0 STATUS
// mask. An accepted request stalls the pipeline, gives CP0 a one-cycle
// `exception` pulse with cause/epc, and then redirects the PC to the vector.
// ERET is handled as a one-cycle `eret` pulse with a PC redirect to EPC.
//
// Ports:
//   clk          single clock, rising edge
//   rst          asynchronous active-low reset
//   instr_valid  an instruction executes this cycle
//   instr_pc     PC of the executing instruction
//   syscall_i    decoded SYSCALL
//   break_i      decoded BREAK
//   teq_i        decoded TEQ
//   teq_eq       rs == rt for TEQ
//   eret_i       decoded ERET
//   mtc0_i       decoded MTC0 (CP0 write port busy)
//   irq          external interrupt, asynchronous level
//   status       CP0 STATUS (bit0 global, bits1..4 SYSCALL/BREAK/TEQ/INT)
//   exception    one-cycle entry pulse to CP0
//   cause        cause code to CP0
//   epc          PC to CP0
//   eret         one-cycle return pulse to CP0
//   pc_sel       next PC comes from CP0 exc_addr
//   stall        hold PC and suppress register writes
//   busy         FSM is not in IDLE
// ----------------------------------------------------------------------------
module exc_req_ctrl #(
   parameter logic [4:0] C_SYSCALL = 5'b01000,
   parameter logic [4:0] C_BREAK   = 5'b01001,
   parameter logic [4:0] C_TEQ     = 5'b01101,
   parameter logic [4:0] C_INT     = 5'b00000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   input  logic [31:0] instr_pc,
   input  logic        syscall_i,
   input  logic        break_i,
   input  logic        teq_i,
   input  logic        teq_eq,
   input  logic        eret_i,
   input  logic        mtc0_i,
   input  logic        irq,
   input  logic [31:0] status,
   output logic        exception,
   output logic [4:0]  cause,
   output logic [31:0] epc,
   output logic        eret,
   output logic        pc_sel,
   output logic        stall,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_ENTER    = 2'd1,
      S_REDIRECT = 2'd2,
      S_ERET     = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic        irq_s1;
   logic        irq_s2;
   logic        irq_s2_q;
   logic        irq_rise;
   logic        irq_pend;

   logic        en_sys;
   logic        en_brk;
   logic        en_teq;
   logic        en_int;
   logic        sel_int;
   logic        take;
   logic        take_eret;
   logic [4:0]  cause_nxt;
   logic [4:0]  cause_q;
   logic [31:0] epc_q;

   // Bits above the five mask bits have no meaning to this block.
   logic        unused_status;
   assign unused_status = ^status[31:5];

   // Request qualification. The interrupt is held back while MTC0 owns the
   // CP0 write port; a trap in the same cycle still wins on priority anyway.
   // The rst term keeps stall low while reset is asserted.
   always_comb begin
      en_sys    = status[0] & status[1] & syscall_i;
      en_brk    = status[0] & status[2] & break_i;
      en_teq    = status[0] & status[3] & teq_i & teq_eq;
      en_int    = status[0] & status[4] & irq_pend & ~mtc0_i;
      take      = rst & (state == S_IDLE) & instr_valid
                  & (en_sys | en_brk | en_teq | en_int);
      take_eret = rst & (state == S_IDLE) & instr_valid & eret_i & ~take;
      sel_int   = 1'b0;
      cause_nxt = C_INT;
      if (en_sys) begin
         cause_nxt = C_SYSCALL;
      end else if (en_brk) begin
         cause_nxt = C_BREAK;
      end else if (en_teq) begin
         cause_nxt = C_TEQ;
      end else begin
         cause_nxt = C_INT;
         sel_int   = en_int;
      end
   end

   assign irq_rise = irq_s2 & ~irq_s2_q;

   // Interrupt synchronizer, edge register and sticky pending flag. A new
   // rising edge wins over a clear in the same cycle so it is never lost.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         irq_s1   <= 1'b0;
         irq_s2   <= 1'b0;
         irq_s2_q <= 1'b0;
         irq_pend <= 1'b0;
      end else begin
         irq_s1   <= irq;
         irq_s2   <= irq_s1;
         irq_s2_q <= irq_s2;
         irq_pend <= (irq_pend & ~(take & sel_int)) | irq_rise;
      end
   end

   // cause/epc are captured on the detection edge and held for CP0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cause_q <= 5'd0;
         epc_q   <= 32'd0;
      end else if (take) begin
         cause_q <= cause_nxt;
         epc_q   <= instr_pc;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: exception entry takes precedence over ERET.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (take) begin
               state_nxt = S_ENTER;
            end else if (take_eret) begin
               state_nxt = S_ERET;
            end
         end
         S_ENTER:    state_nxt = S_REDIRECT;
         S_REDIRECT: state_nxt = S_IDLE;
         S_ERET:     state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   // Output decode. stall covers the detection cycle combinationally.
   always_comb begin
      exception = 1'b0;
      eret      = 1'b0;
      pc_sel    = 1'b0;
      stall     = take;
      busy      = (state != S_IDLE);
      case (state)
         S_ENTER: begin
            exception = 1'b1;
            stall     = 1'b1;
         end
         S_REDIRECT: begin
            pc_sel = 1'b1;
            stall  = 1'b1;
         end
         S_ERET: begin
            eret   = 1'b1;
            pc_sel = 1'b1;
         end
         default: ;
      endcase
   end

   assign cause = cause_q;
   assign epc   = epc_q;

endmodule

// File: tb/tb_exc_req_ctrl.sv
// ----------------------------------------------------------------------------
// tb_exc_req_ctrl
// Directed bench for exc_req_ctrl. Inputs change 2 time units after each
// rising edge and outputs are observed 1 unit later, away from the edge.
// ----------------------------------------------------------------------------
module tb_exc_req_ctrl;

   logic        clk;
   logic        rst;
   logic        instr_valid;
   logic [31:0] instr_pc;
   logic        syscall_i;
   logic        break_i;
   logic        teq_i;
   logic        teq_eq;
   logic        eret_i;
   logic        mtc0_i;
   logic        irq;
   logic [31:0] status;
   logic        exception;
   logic [4:0]  cause;
   logic [31:0] epc;
   logic        eret;
   logic        pc_sel;
   logic        stall;
   logic        busy;

   int compared   = 0;
   int mismatched = 0;

   exc_req_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .instr_valid (instr_valid),
      .instr_pc    (instr_pc),
      .syscall_i   (syscall_i),
      .break_i     (break_i),
      .teq_i       (teq_i),
      .teq_eq      (teq_eq),
      .eret_i      (eret_i),
      .mtc0_i      (mtc0_i),
      .irq         (irq),
      .status      (status),
      .exception   (exception),
      .cause       (cause),
      .epc         (epc),
      .eret        (eret),
      .pc_sel      (pc_sel),
      .stall       (stall),
      .busy        (busy)
   );

   // 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Drive the instruction-side inputs, then let combinational outputs settle.
   task automatic applyStimulus(input logic v, input logic [31:0] pc,
                                input logic sys, input logic brk,
                                input logic teq, input logic teqeq,
                                input logic er, input logic mtc);
      instr_valid = v;
      instr_pc    = pc;
      syscall_i   = sys;
      break_i     = brk;
      teq_i       = teq;
      teq_eq      = teqeq;
      eret_i      = er;
      mtc0_i      = mtc;
      #1;
   endtask

   task automatic checkVal(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag, input logic e_exc,
                              input logic e_eret, input logic e_pcsel,
                              input logic e_stall, input logic e_busy);
      checkVal({tag, ".exception"}, {31'd0, exception}, {31'd0, e_exc});
      checkVal({tag, ".eret"},      {31'd0, eret},      {31'd0, e_eret});
      checkVal({tag, ".pc_sel"},    {31'd0, pc_sel},    {31'd0, e_pcsel});
      checkVal({tag, ".stall"},     {31'd0, stall},     {31'd0, e_stall});
      checkVal({tag, ".busy"},      {31'd0, busy},      {31'd0, e_busy});
   endtask

   // Pulse irq with no instruction executing so nothing is taken meanwhile.
   task automatic pulseIrq();
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      irq = 1'b1;
      repeat (4) tick();
      irq = 1'b0;
      repeat (4) tick();
   endtask

   initial begin
      rst    = 1'b0;
      irq    = 1'b0;
      status = 32'h1F;
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      $display("[TB] reset");
      repeat (2) tick();
      checkOutput("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkVal("reset.cause", {27'd0, cause}, 32'd0);
      checkVal("reset.epc", epc, 32'd0);
      rst = 1'b1;
      tick();

      $display("[TB] SYSCALL entry");
      applyStimulus(1'b1, 32'h00400020, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("sys.c0", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 32'h00400024, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("sys.c1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      checkVal("sys.cause", {27'd0, cause}, 32'h08);
      checkVal("sys.epc", epc, 32'h00400020);
      tick(); #1;
      checkOutput("sys.c2", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      tick(); #1;
      checkOutput("sys.c3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("[TB] SYSCALL and BREAK together");
      applyStimulus(1'b1, 32'h00400040, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("both.c0", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 32'h00400044, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("both.c1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      checkVal("both.cause", {27'd0, cause}, 32'h08);
      tick(); #1;
      checkOutput("both.c2", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      tick(); #1;
      checkOutput("both.c3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("[TB] masked SYSCALL");
      status = 32'h1D;
      applyStimulus(1'b1, 32'h00400048, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("mask.c0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 32'h0040004C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("mask.c1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      status = 32'h1F;

      $display("[TB] TEQ");
      applyStimulus(1'b1, 32'h00400050, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("teqne.c0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 32'h00400060, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("teqne.c1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 32'h00400064, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("teq.c1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      checkVal("teq.cause", {27'd0, cause}, 32'h0D);
      checkVal("teq.epc", epc, 32'h00400060);
      repeat (2) tick();

      $display("[TB] masked interrupt held pending");
      status = 32'h0F;
      pulseIrq();
      checkVal("irqmask.pend", {31'd0, dut.irq_pend}, 32'd1);
      applyStimulus(1'b1, 32'h00400080, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("irqmask.c0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); #1;
      checkOutput("irqmask.c1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkVal("irqmask.pend2", {31'd0, dut.irq_pend}, 32'd1);
      status = 32'h1F;
      applyStimulus(1'b1, 32'h00400084, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("irq.c0", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 32'h00400088, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("irq.c1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      checkVal("irq.cause", {27'd0, cause}, 32'h00);
      checkVal("irq.epc", epc, 32'h00400084);
      checkVal("irq.pendclr", {31'd0, dut.irq_pend}, 32'd0);
      repeat (2) tick();

      $display("[TB] interrupt deferred by MTC0");
      pulseIrq();
      applyStimulus(1'b1, 32'h00400090, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("mtc0.c0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 32'h00400094, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("mtc0.c1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 32'h00400098, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("mtc0.c2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      checkVal("mtc0.epc", epc, 32'h00400094);
      repeat (2) tick();

      $display("[TB] ERET");
      applyStimulus(1'b1, 32'h00400100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("eret.c0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 32'h00400104, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("eret.c1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      tick(); #1;
      checkOutput("eret.c2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("[TB] ERET with pending interrupt");
      pulseIrq();
      applyStimulus(1'b1, 32'h00400100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("eretirq.c0", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 32'h00400104, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("eretirq.c1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      checkVal("eretirq.cause", {27'd0, cause}, 32'h00);
      checkVal("eretirq.epc", epc, 32'h00400100);
      repeat (2) tick();

      $display("[TB] reset during ENTER");
      applyStimulus(1'b1, 32'h00400200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 32'h00400204, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("abort.enter", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      rst = 1'b0;
      #1;
      checkOutput("abort.rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkVal("abort.cause", {27'd0, cause}, 32'd0);
      checkVal("abort.epc", epc, 32'd0);
      tick();
      rst = 1'b1;
      tick(); #1;
      checkOutput("abort.post1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); #1;
      checkOutput("abort.post2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/exc_req_ctrl.md
# exc_req_ctrl

Exception-request controller that drives the CP0 exception port. It decodes trap requests from the execute stage (SYSCALL, BREAK, TEQ) and one external interrupt line. It filters them against the CP0 `status` mask, and then sequences a stall, a one-cycle `exception` pulse with `cause`/`epc`, and a PC redirect. It also sequences ERET returns (`eret` pulse plus PC redirect to EPC). It sits between the single-cycle datapath control and CP0; CP0 remains the owner of the STATUS, CAUSE and EPC registers.

## Interface
Parameters:
- `C_SYSCALL`, 5'b01000, cause code for SYSCALL
- `C_BREAK`, 5'b01001, cause code for BREAK
- `C_TEQ`, 5'b01101, cause code for TEQ
- `C_INT`, 5'b00000, cause code for the external interrupt

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  asynchronous, active-low reset
- `instr_valid`  in  1  an instruction is executing this cycle
- `instr_pc`  in  32  PC of the executing instruction
- `syscall_i`, `break_i`, `teq_i`  in  1 each  decoded instruction strobes
- `teq_eq`  in  1  rs==rt for TEQ
- `eret_i`  in  1  decoded ERET
- `mtc0_i`  in  1  decoded MTC0 (CP0 write port busy)
- `irq`  in  1  external interrupt, asynchronous level
- `status`  in  32  CP0 STATUS
- `exception`  out  1  one-cycle entry pulse to CP0
- `cause`  out  5  cause code to CP0
- `epc`  out  32  PC to CP0
- `eret`  out  1  one-cycle return pulse to CP0
- `pc_sel`  out  1  next PC = CP0 `exc_addr`
- `stall`  out  1  hold PC and suppress register writes
- `busy`  out  1  FSM not in IDLE

## Operation
STATUS bit meaning:
- bit0: global enable
- bit1: SYSCALL enable
- bit2: BREAK enable
- bit3: TEQ enable
- bit4: interrupt enable

A request is enabled only if `status[0]` and its own bit are both 1.

Request sources (sampled only in IDLE with `instr_valid`=1):
- SYSCALL: `syscall_i`
- BREAK: `break_i`
- TEQ: `teq_i & teq_eq`
- interrupt: `irq_pend`

Priority: SYSCALL > BREAK > TEQ > interrupt. Masked or lower-priority requests are dropped, except the interrupt.

Interrupt path:
- `irq` passes through a 2-flop synchronizer.
- A rising edge of the synchronized signal sets `irq_pend`.
- `irq_pend` holds while masked and clears only on the edge that enters ENTER with cause `C_INT`.
- If `mtc0_i`=1, an interrupt-only request is deferred, because CP0 gives MTC0 priority over `exception`.

Taking a request:
- `stall` is asserted combinationally in the detection cycle.
- `cause` and `epc` (=`instr_pc`) are latched.
- The FSM moves to ENTER.

FSM states:
- IDLE:
  - enabled request → ENTER.
  - else `eret_i & instr_valid` → ERET.
  - else stay.
- ENTER: `exception`=1, `stall`=1 → REDIRECT.
- REDIRECT: `pc_sel`=1, `stall`=1. CP0 now presents the vector 0x00400004 → IDLE.
- ERET: `eret`=1, `pc_sel`=1, `stall`=0. CP0 presents EPC and shifts STATUS → IDLE.

An ERET that coincides with an enabled interrupt: the interrupt wins. EPC is the ERET's own PC, so the ERET re-executes after the handler.

## Timing
- Reset (`rst`=0, asynchronous): state=IDLE, sync flops=0, `irq_pend`=0.
- Reset values of outputs: `exception`=0, `eret`=0, `pc_sel`=0, `stall`=0, `busy`=0, `cause`=0, `epc`=0.
- Reset asserted mid-sequence aborts it; no further pulses are issued.
- Trap latency:
  - cycle 0: detection, `stall`=1.
  - cycle 1: ENTER, `exception`=1; CP0 captures at the end of cycle 1.
  - cycle 2: REDIRECT, `pc_sel`=1; PC loads the vector at the end of cycle 2.
  - cycle 3: IDLE, handler executes.
- ERET latency: detection cycle 0, then ERET in cycle 1. PC loads EPC at the end of cycle 1.
- Interrupt latency: at least 3 cycles from an `irq` rise to `irq_pend`=1 (2 sync flops plus the edge register).
- `exception` and `eret` are never both 1, and each is exactly one cycle wide.
- `busy`=1 in every non-IDLE state.
- New requests arriving while `busy`=1 are ignored, except that `irq_pend` may still set.

## Test plan
- Reset `status`=0x1F, SYSCALL at `instr_pc`=0x00400020 → cycle 1: `exception`=1, `cause`=01000, `epc`=0x00400020; cycle 2: `pc_sel`=1; cycle 3: `busy`=0.
- SYSCALL and BREAK strobed together → exactly one `exception` pulse, `cause`=01000. With `status`=0x1D (SYSCALL masked), a SYSCALL alone produces no pulse and `stall`=0.
- TEQ with `teq_eq`=0 → no pulse. TEQ with `teq_eq`=1 → `cause`=01101.
- `irq` pulsed while `status`=0x0F → `irq_pend` holds and no pulse. Write `status`=0x1F → pulse with `cause`=00000, `epc`=current PC, `irq_pend` clears.
- `eret_i` at PC 0x00400100 → next cycle `eret`=1 and `pc_sel`=1 for one cycle, `exception`=0. `eret_i` with `irq_pend` set and enabled → interrupt entry with `epc`=0x00400100.
- Drive `rst`=0 during ENTER → all outputs 0 immediately. After release, no residual `exception` or `pc_sel`.
